// File: rtl/fetch_controller_if.sv
// fetch_controller_if: imemory port plus fetch output handshake
//   master (controller): drives imem_address/imem_read_write/imem_data_in, samples imem_data_out,
//                        drives fetch_valid/fetch_pc/fetch_insn, samples fetch_ready
//   slave  (memory + decode side): the mirror image
interface fetch_controller_if;
    logic [31:0] imem_address;
    logic        imem_read_write;
    logic [31:0] imem_data_in;
    logic [31:0] imem_data_out;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_insn;
    modport master (
        output imem_address, imem_read_write, imem_data_in, fetch_valid, fetch_pc, fetch_insn,
        input  imem_data_out, fetch_ready
    );
    modport slave (
        input  imem_address, imem_read_write, imem_data_in, fetch_valid, fetch_pc, fetch_insn,
        output imem_data_out, fetch_ready
    );
endinterface

// File: rtl/fetch_controller.sv
// fetch_controller: owns the PC and presents {pc, instruction} entries to decode
//   i_clock            clock, rising edge
//   i_reset_n          asynchronous active-low reset
//   i_enable           start fetching (IDLE only)
//   i_redirect_valid   load i_redirect_pc and flush the output entry
//   i_redirect_pc      redirect target, must be word aligned
//   i_halt_req         stop issuing fetches (FETCH only)
//   bus                imemory port and fetch valid/ready handshake
//   o_fault            sticky misaligned-redirect flag
//   o_state            0 IDLE, 1 FETCH, 2 HALT, 3 FAULT
//   o_fetch_count      number of captured fetches (wrapping)
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic                       i_clock,
    input  logic                       i_reset_n,
    input  logic                       i_enable,
    input  logic                       i_redirect_valid,
    input  logic [31:0]                i_redirect_pc,
    input  logic                       i_halt_req,
    fetch_controller_if.master         bus,
    output logic                       o_fault,
    output logic [1:0]                 o_state,
    output logic [31:0]                o_fetch_count
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT, S_FAULT} state_t;
    state_t      r_state, w_next_state;
    logic [31:0] r_pc, r_fetch_pc, r_fetch_insn, r_count;
    logic        r_valid, r_fault;
    logic        w_redir_bad, w_redir_ok, w_halt, w_capture;
    // a redirect in FAULT is ignored entirely
    assign w_redir_bad = i_redirect_valid && (r_state != S_FAULT) && (i_redirect_pc[1:0] != 2'b00);
    assign w_redir_ok  = i_redirect_valid && (r_state != S_FAULT) && (i_redirect_pc[1:0] == 2'b00);
    assign w_halt      = (r_state == S_FETCH) && i_halt_req;
    // redirect and halt both suppress the capture of this cycle
    assign w_capture   = (r_state == S_FETCH) && !i_redirect_valid && !i_halt_req
                         && (!r_valid || bus.fetch_ready);
    always_comb begin
        w_next_state = r_state;
        w_next_state = w_redir_bad                      ? S_FAULT :
                       w_redir_ok                       ? S_FETCH :
                       (r_state == S_IDLE && i_enable)  ? S_FETCH :
                       w_halt                           ? S_HALT  : r_state;
    end
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_valid      <= 1'b0;
            r_fetch_pc   <= '0;
            r_fetch_insn <= '0;
            r_fault      <= 1'b0;
            r_count      <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_redir_bad) r_fault <= 1'b1;
            if (w_redir_ok) r_pc <= i_redirect_pc;
            if (w_redir_bad || w_redir_ok) begin
                r_valid <= 1'b0;
            end else if (w_capture) begin
                r_valid      <= 1'b1;
                r_fetch_pc   <= r_pc;
                r_fetch_insn <= bus.imem_data_out;
                r_pc         <= r_pc + PC_STEP;
                r_count      <= r_count + 32'd1;
            end else if (r_valid && bus.fetch_ready) begin
                r_valid <= 1'b0;
            end
        end
    end
    assign bus.imem_address    = r_pc;
    assign bus.imem_read_write = 1'b0;
    assign bus.imem_data_in    = '0;
    assign bus.fetch_valid     = r_valid;
    assign bus.fetch_pc        = r_fetch_pc;
    assign bus.fetch_insn      = r_fetch_insn;
    assign o_fault             = r_fault;
    assign o_state             = r_state;
    assign o_fetch_count       = r_count;
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed fetch sequences with a scoreboard of accepted entries
module tb_fetch_controller;
    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        fault;
    logic [1:0]  state;
    logic [31:0] fetch_count;
    int          n_vec;
    int          n_err;
    logic [31:0] sb[$];

    fetch_controller_if bus ();

    fetch_controller dut (
        .i_clock          (clk),
        .i_reset_n        (rst_n),
        .i_enable         (enable),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .i_halt_req       (halt_req),
        .bus              (bus),
        .o_fault          (fault),
        .o_state          (state),
        .o_fetch_count    (fetch_count)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign bus.imem_data_out = mem(bus.imem_address);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // decode side: every accepted, non-flushed entry must match the scoreboard head
    always @(negedge clk) begin
        if (rst_n && bus.fetch_valid && bus.fetch_ready && !redirect_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got pc %h expected no entry", bus.fetch_pc);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                check("sb_pc", bus.fetch_pc, e);
                check("sb_insn", bus.fetch_insn, mem(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b1;
        enable = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        halt_req = 1'b0;
        bus.fetch_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_valid", {31'd0, bus.fetch_valid}, 32'd0);
        check("rst_fpc", bus.fetch_pc, 32'd0);
        check("rst_finsn", bus.fetch_insn, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_addr", bus.imem_address, 32'h0100_0000);
        check("rst_rw", {31'd0, bus.imem_read_write}, 32'd0);
        check("rst_din", bus.imem_data_in, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_hold", {30'd0, state}, 32'd0);
        // sequential fetch
        sb.push_back(32'h0100_0000);
        sb.push_back(32'h0100_0004);
        enable = 1'b1;
        bus.fetch_ready = 1'b1;
        tick();
        enable = 1'b0;
        check("en_state", {30'd0, state}, 32'd1);
        check("en_valid", {31'd0, bus.fetch_valid}, 32'd0);
        check("en_addr", bus.imem_address, 32'h0100_0000);
        tick();
        check("f0_pc", bus.fetch_pc, 32'h0100_0000);
        check("f0_cnt", fetch_count, 32'd1);
        tick();
        check("f1_pc", bus.fetch_pc, 32'h0100_0004);
        check("f1_cnt", fetch_count, 32'd2);
        // back-pressure
        bus.fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", bus.fetch_pc, 32'h0100_0004);
            check("stall_insn", bus.fetch_insn, mem(32'h0100_0004));
            check("stall_addr", bus.imem_address, 32'h0100_0008);
            check("stall_cnt", fetch_count, 32'd2);
        end
        bus.fetch_ready = 1'b1;
        tick();
        check("f2_pc", bus.fetch_pc, 32'h0100_0008);
        check("f2_cnt", fetch_count, 32'd3);
        // redirect while held, then redirect with ready
        bus.fetch_ready = 1'b0;
        sb.push_back(32'h0100_0100);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0100_0100;
        tick();
        check("rd_valid", {31'd0, bus.fetch_valid}, 32'd0);
        check("rd_addr", bus.imem_address, 32'h0100_0100);
        redirect_valid = 1'b0;
        bus.fetch_ready = 1'b1;
        tick();
        check("rd_pc", bus.fetch_pc, 32'h0100_0100);
        tick();
        check("rd_pc2", bus.fetch_pc, 32'h0100_0104);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0100_0200;
        tick();
        check("rdr_valid", {31'd0, bus.fetch_valid}, 32'd0);
        check("rdr_addr", bus.imem_address, 32'h0100_0200);
        redirect_valid = 1'b0;
        sb.push_back(32'h0100_0200);
        tick();
        check("rdr_pc", bus.fetch_pc, 32'h0100_0200);
        // halt and resume
        halt_req = 1'b1;
        tick();
        check("halt_state", {30'd0, state}, 32'd2);
        check("halt_cnt", fetch_count, 32'd6);
        check("halt_valid", {31'd0, bus.fetch_valid}, 32'd0);
        halt_req = 1'b0;
        tick();
        check("halt_state2", {30'd0, state}, 32'd2);
        check("halt_cnt2", fetch_count, 32'd6);
        check("halt_addr", bus.imem_address, 32'h0100_0204);
        sb.push_back(32'h0100_0040);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0100_0040;
        tick();
        check("res_state", {30'd0, state}, 32'd1);
        check("res_addr", bus.imem_address, 32'h0100_0040);
        redirect_valid = 1'b0;
        tick();
        check("res_pc", bus.fetch_pc, 32'h0100_0040);
        tick();
        // PC wrap
        sb.push_back(32'hFFFF_FFFC);
        sb.push_back(32'h0000_0000);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        check("wr_valid", {31'd0, bus.fetch_valid}, 32'd0);
        check("wr_addr", bus.imem_address, 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        tick();
        check("wr_pc", bus.fetch_pc, 32'hFFFF_FFFC);
        tick();
        check("wr_pc0", bus.fetch_pc, 32'h0000_0000);
        check("wr_addr4", bus.imem_address, 32'h0000_0004);
        check("wr_cnt", fetch_count, 32'd10);
        tick();
        // misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc = 32'h0100_0102;
        tick();
        check("flt_state", {30'd0, state}, 32'd3);
        check("flt_fault", {31'd0, fault}, 32'd1);
        check("flt_valid", {31'd0, bus.fetch_valid}, 32'd0);
        check("flt_addr", bus.imem_address, 32'h0000_0008);
        redirect_pc = 32'h0100_0000;
        tick();
        check("flt_state2", {30'd0, state}, 32'd3);
        check("flt_addr2", bus.imem_address, 32'h0000_0008);
        check("flt_cnt", fetch_count, 32'd11);
        check("flt_valid2", {31'd0, bus.fetch_valid}, 32'd0);
        redirect_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("ar_fault", {31'd0, fault}, 32'd0);
        check("ar_state", {30'd0, state}, 32'd0);
        check("ar_addr", bus.imem_address, 32'h0100_0000);
        check("ar_cnt", fetch_count, 32'd0);
        check("sb_left", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
